uart_rx_fifo: RTL

Byte buffer placed directly downstream of the UART receiver. It captures each received byte on the receiver's one-cycle ready strobe. It presents the bytes to the consumer in arrival order through a valid/ready handshake with first-word fall-through. It also reports occupancy, full and empty status, and a sticky overflow flag for bytes lost while the buffer was full.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_fifo_mem.sv | 28 ++
 rtl/uart_rx_fifo.sv | 92 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: byte width and default
// receive-FIFO geometry.
package uart_pkg;

  localparam int DATA_W        = 8;
  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_FIFO_AW    = 4;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// combinational read port, used as first-word fall-through storage.
module uart_fifo_mem #(
  parameter int DEPTH  = uart_pkg::RX_FIFO_DEPTH,
  parameter int ADDR_W = uart_pkg::RX_FIFO_AW,
  parameter int DATA_W = uart_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset; occupancy is tracked by the pointers and
  // count, so stale contents are never presented as valid.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind the UART receiver: captures bytes on the receiver strobe,
// presents them in order with valid/ready, and flags bytes lost while full.
module uart_rx_fifo #(
  parameter int DEPTH  = uart_pkg::RX_FIFO_DEPTH,
  parameter int ADDR_W = uart_pkg::RX_FIFO_AW,
  parameter int DATA_W = uart_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_stb,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same edge, so a full buffer still accepts a
  // write when the consumer is reading.
  assign w_pop  = !w_empty && rd_ready;
  assign w_push = wr_stb && (!w_full || w_pop);
  assign w_drop = wr_stb && !w_push;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (ADDR_W + 1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (ADDR_W + 1)'(1);
      end
      // A fresh drop takes priority over a clear in the same cycle.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data)
  );

  assign count    = r_count;
  assign full     = w_full;
  assign empty    = w_empty;
  assign rd_valid = !w_empty;
  assign overflow = r_overflow;

endmodule : uart_rx_fifo
